// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state encoding, display width and index helper for the display arbiter
package seg7_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, LINGER = 2'd2} state_t;
    localparam int BITS_W = 16;
    function automatic logic [2:0] wrap_inc(input logic [2:0] i, input int n);
        return (int'(i) == n - 1) ? 3'd0 : i + 3'd1;
    endfunction
endpackage

// File: rtl/seg7_display_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or after rr_ptr (mod N_REQ)
module rr_pick import seg7_pkg::*; #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       rr_ptr,
    output logic [2:0]       idx,
    output logic             any
);
    logic [7:0] req_x;
    logic [2:0] j;
    assign req_x = 8'(req);
    assign any = |req;
    // scan farthest offset first so the closest match to rr_ptr overwrites last
    always_comb begin
        idx = '0;
        j = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = 3'((int'(rr_ptr) + k) % N_REQ);
            if (req_x[j]) idx = j;
        end
    end
endmodule

// File: rtl/seg7_display_arb.sv
// seg7_display_arb: round-robin owner of the shared 4-digit display with minimum hold and quantum
module seg7_display_arb import seg7_pkg::*; #(
    parameter int N_REQ    = 4,
    parameter int MIN_HOLD = 50_000_000,
    parameter int QUANTUM  = 200_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [BITS_W*N_REQ-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    output logic [BITS_W-1:0]       bits_out,
    output logic [2:0]              owner,
    output logic                    busy
);
    localparam int CW = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0] MIN_M1  = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] QNT_M1  = CW'(QUANTUM - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d, win_gnt, own_gnt;
    logic [BITS_W-1:0]  bits_q, bits_d;
    logic [2:0]         owner_q, owner_d, rr_ptr_q, rr_ptr_d, win;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [BITS_W-1:0]  dv [8];
    logic [7:0]         req_x;
    logic               any, own_req, others, rel;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .idx    (win),
        .any    (any)
    );

    for (genvar g = 0; g < 8; g++) begin : g_dv
        if (g < N_REQ) begin : g_on
            assign dv[g] = data[BITS_W*g +: BITS_W];
        end else begin : g_off
            assign dv[g] = '0;
        end
    end

    assign req_x   = 8'(req);
    assign own_req = req_x[owner_q];
    assign others  = |(req & ~gnt_q);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        win_gnt = '0;
        own_gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_gnt[i] = (3'(i) == win);
            own_gnt[i] = (3'(i) == owner_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        bits_d   = bits_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        rel      = 1'b0;
        case (state_q)
            IDLE: if (any) begin
                owner_d = win;
                gnt_d   = win_gnt;
                cnt_d   = '0;
                state_d = OWN;
            end
            OWN: begin
                bits_d = dv[owner_q];
                cnt_d  = cnt_inc;
                if (!own_req && cnt_q >= MIN_M1) rel = 1'b1;
                else if (!own_req) begin
                    state_d = LINGER;
                    gnt_d   = '0;
                end else if (others && cnt_q >= QNT_M1) rel = 1'b1;
            end
            LINGER: begin
                cnt_d = cnt_inc;
                if (own_req) begin
                    state_d = OWN;
                    gnt_d   = own_gnt;
                end else if (cnt_q >= MIN_M1) rel = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            gnt_d    = '0;
            rr_ptr_d = wrap_inc(owner_q, N_REQ);
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            bits_q   <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            bits_q   <= bits_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign bits_out = bits_q;
    assign owner    = owner_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_seg7_display_arb.sv
// tb_seg7_display_arb: directed checks of grant order, hold, linger and preemption
module tb_seg7_display_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] data = '0;
    logic [3:0]  gnt;
    logic [15:0] bits_out;
    logic [2:0]  owner;
    logic        busy;
    int checks = 0;
    int failures = 0;
    logic [15:0] prev_bits = '0;
    logic        prev_own = 1'b0;
    logic        skip = 1'b1;
    logic [15:0] dv_tb [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};

    seg7_display_arb #(.N_REQ(4), .MIN_HOLD(4), .QUANTUM(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .bits_out (bits_out),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        skip = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_bits", 32'(bits_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        checks++;
        assert ($onehot0(gnt)) else begin
            failures++;
            $error("FAIL onehot observed=%b expected=onehot0", gnt);
        end
        if (!skip) begin
            checks++;
            assert (bits_out === prev_bits || prev_own) else begin
                failures++;
                $error("FAIL bits_stable observed=%h expected=%h", bits_out, prev_bits);
            end
        end
        skip = 1'b0;
        prev_bits = bits_out;
        prev_own = |gnt;
    end

    initial begin
        #2;
        do_reset();
        data[15:0] = 16'h1234;
        req = 4'b0001;
        tick(1);
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_bits_lat", 32'(bits_out), 32'h0);
        tick(1);
        chk("single_bits", 32'(bits_out), 32'h1234);
        data[15:0] = 16'hABCD;
        tick(1);
        chk("single_track", 32'(bits_out), 32'hABCD);
        do_reset();
        data = {dv_tb[3], dv_tb[2], dv_tb[1], dv_tb[0]};
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("rr_gnt", 32'(gnt), 32'(1 << k));
            chk("rr_owner", 32'(owner), 32'(k));
            tick(1);
            chk("rr_bits", 32'(bits_out), 32'(dv_tb[k]));
            tick(6);
            chk("rr_hold", 32'(gnt), 32'(1 << k));
            tick(1);
            chk("rr_idle_gnt", 32'(gnt), 32'h0);
            chk("rr_idle_busy", 32'(busy), 32'h0);
            chk("rr_idle_bits", 32'(bits_out), 32'(dv_tb[k]));
        end
        tick(1);
        chk("rr_wrap_gnt", 32'(gnt), 32'h1);
        chk("rr_wrap_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        do_reset();
        data = '0;
        data[15:0] = 16'h5A5A;
        req = 4'b0001;
        tick(1);
        chk("mh_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick(1);
        chk("mh_linger_gnt", 32'(gnt), 32'h0);
        chk("mh_linger_busy", 32'(busy), 32'h1);
        chk("mh_linger_bits", 32'(bits_out), 32'h5A5A);
        data[15:0] = 16'hFFFF;
        tick(1);
        chk("mh_frozen", 32'(bits_out), 32'h5A5A);
        tick(1);
        chk("mh_cnt3_busy", 32'(busy), 32'h1);
        tick(1);
        chk("mh_expire_busy", 32'(busy), 32'h0);
        chk("mh_expire_bits", 32'(bits_out), 32'h5A5A);
        req = 4'b0001;
        tick(1);
        chk("rq_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick(1);
        chk("rq_linger_bits", 32'(bits_out), 32'hFFFF);
        chk("rq_linger_gnt", 32'(gnt), 32'h0);
        tick(1);
        req = 4'b0001;
        tick(1);
        chk("rq_regrant_gnt", 32'(gnt), 32'h1);
        chk("rq_regrant_busy", 32'(busy), 32'h1);
        data[15:0] = 16'h1357;
        tick(1);
        chk("rq_track", 32'(bits_out), 32'h1357);
        chk("rq_keep_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick(1);
        chk("rq_release_gnt", 32'(gnt), 32'h0);
        chk("rq_release_busy", 32'(busy), 32'h0);
        req = 4'b0001;
        tick(1);
        req = 4'b0000;
        tick(3);
        req = 4'b0001;
        tick(1);
        chk("tie_reassert_gnt", 32'(gnt), 32'h1);
        chk("tie_reassert_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        do_reset();
        data = '0;
        data[15:0] = 16'h0A0A;
        data[47:32] = 16'h2C2C;
        req = 4'b0001;
        tick(1);
        chk("pre_gnt0", 32'(gnt), 32'h1);
        req = 4'b0101;
        tick(7);
        chk("pre_hold", 32'(gnt), 32'h1);
        tick(1);
        chk("pre_drop_gnt", 32'(gnt), 32'h0);
        chk("pre_drop_busy", 32'(busy), 32'h0);
        tick(1);
        chk("pre_gnt2", 32'(gnt), 32'h4);
        chk("pre_owner2", 32'(owner), 32'h2);
        tick(1);
        chk("pre_bits2", 32'(bits_out), 32'h2C2C);
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        tick(20);
        chk("alone_gnt", 32'(gnt), 32'h1);
        chk("alone_busy", 32'(busy), 32'h1);
        chk("alone_owner", 32'(owner), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
